// File: rtl/regmap_split_bank.sv
// regmap_split_bank
// Parametrised register bank. Each bus word at BASE_ADDR+k is split into
// FPW = DATA_W/FIELD_W packed field registers. A single write updates every
// strobed field of the addressed word at once. Fields are either plain
// read/write or write-1-to-clear with hardware set inputs (set wins over clear).
// Reads are registered, and accesses outside the mapped window are flagged.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   write_i        write request (one cycle)
//   read_i         read request (one cycle)
//   addr_i         word address
//   write_data_i   write word
//   write_strb_i   per-field write enable within the addressed word
//   read_data_o    registered read word, holds until the next accepted read
//   read_valid_o   pulses the cycle after an accepted read
//   addr_err_o     pulses the cycle after any access to an unmapped address
//   reg_out_o      all field values, field f at [f*FIELD_W +: FIELD_W]
//   hw_set_i       per-bit hardware set for W1C fields (ignored for RW fields)
module regmap_split_bank #(
  parameter int DATA_W    = 4,
  parameter int FIELD_W   = 2,
  parameter int NUM_WORDS = 4,
  parameter int ADDR_W    = 3,
  parameter int BASE_ADDR = 1,
  parameter logic [NUM_WORDS*(DATA_W/FIELD_W)-1:0] W1C_MASK = '0,
  parameter logic [FIELD_W-1:0] RESET_VALUE = '0
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      write_i,
  input  logic                                      read_i,
  input  logic [ADDR_W-1:0]                         addr_i,
  input  logic [DATA_W-1:0]                         write_data_i,
  input  logic [DATA_W/FIELD_W-1:0]                 write_strb_i,
  output logic [DATA_W-1:0]                         read_data_o,
  output logic                                      read_valid_o,
  output logic                                      addr_err_o,
  output logic [NUM_WORDS*DATA_W-1:0]               reg_out_o,
  input  logic [NUM_WORDS*DATA_W-1:0]               hw_set_i
);

  localparam int FPW   = DATA_W / FIELD_W;
  localparam int NF    = NUM_WORDS * FPW;
  localparam int LIMIT = BASE_ADDR + NUM_WORDS;

  // Address window bounds kept one bit wider than the bus address so that
  // BASE_ADDR+NUM_WORDS can equal 2**ADDR_W without wrapping to zero.
  localparam logic [ADDR_W:0] BASE_EXT  = BASE_ADDR[ADDR_W:0];
  localparam logic [ADDR_W:0] LIMIT_EXT = LIMIT[ADDR_W:0];

  if (DATA_W % FIELD_W != 0) begin : g_bad_width
    $error("regmap_split_bank: DATA_W must be a multiple of FIELD_W");
  end
  if (LIMIT > (1 << ADDR_W)) begin : g_bad_range
    $error("regmap_split_bank: BASE_ADDR+NUM_WORDS exceeds address space");
  end

  logic [NF*FIELD_W-1:0] fields_q, fields_d;
  logic [DATA_W-1:0]     read_data_q, read_data_d;
  logic                  read_valid_q, read_valid_d;
  logic                  addr_err_q, addr_err_d;

  logic [ADDR_W:0]       addrExt;
  logic [ADDR_W:0]       wordIdx;
  logic                  mapped;
  logic [NUM_WORDS-1:0]  wordSel;
  logic [NF-1:0]         fieldHit;
  logic [DATA_W-1:0]     readWord;

  assign addrExt = {1'b0, addr_i};
  assign mapped  = (addrExt >= BASE_EXT) && (addrExt < LIMIT_EXT);
  assign wordIdx = addrExt - BASE_EXT;

  // One-hot word select; all zero when the address is outside the window.
  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word_sel
    assign wordSel[k] = mapped && (wordIdx == (ADDR_W+1)'(k));
  end

  // A field is written when its word is addressed and its lane is strobed.
  for (genvar f = 0; f < NF; f++) begin : g_field_hit
    assign fieldHit[f] = write_i && wordSel[f/FPW] && write_strb_i[f%FPW];
  end

  // Field next state. W1C fields clear the strobed write bits and then OR in
  // the hardware set bits, so a simultaneous set and clear leaves the bit set.
  always_comb begin
    fields_d = fields_q;
    for (int f = 0; f < NF; f++) begin
      if (W1C_MASK[f]) begin
        fields_d[f*FIELD_W +: FIELD_W] =
          (fields_q[f*FIELD_W +: FIELD_W] &
           ~(fieldHit[f] ? write_data_i[(f%FPW)*FIELD_W +: FIELD_W] : '0)) |
          hw_set_i[f*FIELD_W +: FIELD_W];
      end else if (fieldHit[f]) begin
        fields_d[f*FIELD_W +: FIELD_W] = write_data_i[(f%FPW)*FIELD_W +: FIELD_W];
      end
    end
  end

  // Read mux uses pre-edge field state, giving read-before-write ordering.
  always_comb begin
    readWord = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (wordSel[k]) begin
        readWord = fields_q[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    read_data_d  = (read_i && mapped) ? readWord : read_data_q;
    read_valid_d = read_i && mapped;
    addr_err_d   = (read_i || write_i) && !mapped;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fields_q     <= {NF{RESET_VALUE}};
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      fields_q     <= fields_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign read_data_o  = read_data_q;
  assign read_valid_o = read_valid_q;
  assign addr_err_o   = addr_err_q;
  assign reg_out_o    = fields_q;

endmodule

// File: tb/tb_regmap_split_bank.sv
// Testbench for regmap_split_bank with default geometry (4 words of two 2-bit
// fields at addresses 1..4) and fields 2 and 7 configured as W1C.
module tb_regmap_split_bank;

  localparam logic [7:0] MASK = 8'b1000_0100;
  localparam int BASE = 1;
  localparam int NW   = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        write_i;
  logic        read_i;
  logic [2:0]  addr_i;
  logic [3:0]  write_data_i;
  logic [1:0]  write_strb_i;
  logic [3:0]  read_data_o;
  logic        read_valid_o;
  logic        addr_err_o;
  logic [15:0] reg_out_o;
  logic [15:0] hw_set_i;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state: one integer per field plus read-path registers.
  int mField[8];
  int mReadData;
  int mValid;
  int mErr;

  regmap_split_bank #(
    .DATA_W(4), .FIELD_W(2), .NUM_WORDS(4), .ADDR_W(3), .BASE_ADDR(1),
    .W1C_MASK(MASK), .RESET_VALUE(2'b00)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .write_i(write_i), .read_i(read_i),
    .addr_i(addr_i), .write_data_i(write_data_i), .write_strb_i(write_strb_i),
    .read_data_o(read_data_o), .read_valid_o(read_valid_o),
    .addr_err_o(addr_err_o), .reg_out_o(reg_out_o), .hw_set_i(hw_set_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [3:0]  wdata;
    logic [1:0]  strb;
    logic [15:0] hwset;
    logic [15:0] expRegOut;
    logic [3:0]  expRdata;
    logic        expValid;
    logic        expErr;
  } vector_t;

  vector_t vecs[18];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, return 1 time unit after it.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [2:0] addr,
                               input logic [3:0] wdata, input logic [1:0] strb,
                               input logic [15:0] hwset);
    write_i      = wr;
    read_i       = rd;
    addr_i       = addr;
    write_data_i = wdata;
    write_strb_i = strb;
    hw_set_i     = hwset;
    @(posedge clk_i);
    #1;
  endtask

  // Model one clock edge from the rules: mapped window, per-field strobe,
  // W1C clear-then-set, read of the pre-edge word.
  task automatic modelStep(input logic wr, input logic rd, input int addr,
                           input int wdata, input int strb, input int hwset);
    int isMapped;
    int word;
    int nextField[8];
    isMapped = (addr >= BASE) && (addr < BASE + NW);
    word     = addr - BASE;
    mValid   = (rd && isMapped) ? 1 : 0;
    mErr     = ((rd || wr) && !isMapped) ? 1 : 0;
    if (mValid == 1) mReadData = mField[word*2] + 4 * mField[word*2+1];
    for (int f = 0; f < 8; f++) begin
      int lane, slice, setBits, strobed;
      lane    = f % 2;
      slice   = (wdata >> (lane*2)) % 4;
      setBits = (hwset >> (f*2)) % 4;
      strobed = wr && isMapped && (f/2 == word) && ((strb >> lane) % 2 == 1);
      nextField[f] = mField[f];
      if (MASK[f]) begin
        nextField[f] = (mField[f] & (strobed ? (3 - slice) : 3)) | setBits;
      end else if (strobed) begin
        nextField[f] = slice;
      end
    end
    for (int f = 0; f < 8; f++) mField[f] = nextField[f];
  endtask

  function automatic int modelRegOut();
    int v = 0;
    for (int f = 0; f < 8; f++) v += mField[f] << (f*2);
    return v;
  endfunction

  initial begin
    // Directed vectors from reset; expected values worked out by hand.
    vecs[0]  = '{1'b0, 1'b0, 3'd0, 4'h0, 2'b00, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'd1, 4'hB, 2'b11, 16'h0000, 16'h000B, 4'h0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'd1, 4'h0, 2'b00, 16'h0000, 16'h000B, 4'hB, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'd1, 4'h4, 2'b10, 16'h0000, 16'h0007, 4'hB, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 3'd1, 4'h0, 2'b00, 16'h0000, 16'h0007, 4'h7, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 3'd0, 4'h0, 2'b00, 16'h0030, 16'h0037, 4'h7, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'd2, 4'h1, 2'b01, 16'h0000, 16'h0027, 4'h7, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'd2, 4'h1, 2'b01, 16'h0010, 16'h0037, 4'h7, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 3'd3, 4'hF, 2'b11, 16'h0000, 16'h0F37, 4'h0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3'd3, 4'h0, 2'b00, 16'h0000, 16'h0F37, 4'hF, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 3'd0, 4'hF, 2'b11, 16'h0000, 16'h0F37, 4'hF, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 3'd5, 4'hF, 2'b11, 16'h0000, 16'h0F37, 4'hF, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 3'd7, 4'h0, 2'b00, 16'h0000, 16'h0F37, 4'hF, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 3'd7, 4'h0, 2'b00, 16'h0000, 16'h0F37, 4'hF, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 3'd4, 4'hF, 2'b11, 16'h0000, 16'h3F37, 4'hF, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 3'd0, 4'h0, 2'b00, 16'h8000, 16'hBF37, 4'hF, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 3'd4, 4'h0, 2'b00, 16'h0000, 16'hBF37, 4'hB, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 3'd4, 4'hB, 2'b10, 16'h0000, 16'h3F37, 4'hB, 1'b0, 1'b0};

    rst_i = 1'b1;
    write_i = 1'b0; read_i = 1'b0; addr_i = '0;
    write_data_i = '0; write_strb_i = '0; hw_set_i = '0;
    #12;
    checkOutput("reset_regout", 32'(reg_out_o), 32'h0);
    checkOutput("reset_rdata", 32'(read_data_o), 32'h0);
    checkOutput("reset_valid", 32'(read_valid_o), 32'h0);
    checkOutput("reset_err", 32'(addr_err_o), 32'h0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata,
                    vecs[i].strb, vecs[i].hwset);
      checkOutput($sformatf("vec%0d_regout", i), 32'(reg_out_o), 32'(vecs[i].expRegOut));
      checkOutput($sformatf("vec%0d_rdata", i), 32'(read_data_o), 32'(vecs[i].expRdata));
      checkOutput($sformatf("vec%0d_valid", i), 32'(read_valid_o), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_err", i), 32'(addr_err_o), 32'(vecs[i].expErr));
    end

    // Asynchronous reset between edges with a read in flight.
    applyStimulus(1'b1, 1'b0, 3'd1, 4'hB, 2'b11, 16'h0000);
    checkOutput("prerst_regout", 32'(reg_out_o), 32'h3F3B);
    write_i = 1'b0;
    read_i  = 1'b1;
    addr_i  = 3'd1;
    #3;
    rst_i = 1'b1;
    #1;
    checkOutput("async_rst_regout", 32'(reg_out_o), 32'h0);
    checkOutput("async_rst_rdata", 32'(read_data_o), 32'h0);
    checkOutput("async_rst_valid", 32'(read_valid_o), 32'h0);
    read_i = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput("held_rst_valid", 32'(read_valid_o), 32'h0);
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 2'b00, 16'h0000);
    checkOutput("post_rst_valid", 32'(read_valid_o), 32'h0);
    checkOutput("post_rst_err", 32'(addr_err_o), 32'h0);
    checkOutput("post_rst_regout", 32'(reg_out_o), 32'h0);

    // Randomised traffic against the reference model, starting from reset.
    for (int f = 0; f < 8; f++) mField[f] = 0;
    mReadData = 0;
    mValid = 0;
    mErr = 0;
    for (int n = 0; n < 500; n++) begin
      logic        wr, rd;
      logic [2:0]  addr;
      logic [3:0]  wdata;
      logic [1:0]  strb;
      logic [15:0] hwset;
      wr    = ($urandom_range(0, 99) < 50);
      rd    = ($urandom_range(0, 99) < 40);
      addr  = 3'($urandom_range(0, 7));
      wdata = 4'($urandom);
      strb  = 2'($urandom);
      hwset = 16'($urandom & $urandom & $urandom);
      modelStep(wr, rd, int'(addr), int'(wdata), int'(strb), int'(hwset));
      applyStimulus(wr, rd, addr, wdata, strb, hwset);
      checkOutput($sformatf("rnd%0d_regout", n), 32'(reg_out_o), 32'(modelRegOut()));
      checkOutput($sformatf("rnd%0d_rdata", n), 32'(read_data_o), 32'(mReadData));
      checkOutput($sformatf("rnd%0d_valid", n), 32'(read_valid_o), 32'(mValid));
      checkOutput($sformatf("rnd%0d_err", n), 32'(addr_err_o), 32'(mErr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/regmap_split_bank.md
Name: regmap_split_bank

Overview:
Parametrised register bank that maps a bus word onto several narrower field registers, so one write at one address updates multiple packed fields. It generalises the fixed two-field split-write register map. New over that map: multiple word addresses, per-field write strobes, a registered read path with valid flag, write-1-to-clear (W1C) status fields with hardware set inputs, and out-of-range address detection. It sits between the control bus decoder and the datapath blocks that consume the field values.

Parameters:
DATA_W, 4, bus word width; must be a multiple of FIELD_W.
FIELD_W, 2, width of one field register.
NUM_WORDS, 4, number of mapped word addresses.
ADDR_W, 3, address width.
BASE_ADDR, 1, address of word 0; word k is at BASE_ADDR+k.
W1C_MASK, 0, NF-bit mask; bit f=1 makes field f W1C, else read/write (RW).
RESET_VALUE, 0, reset value of every field.
Derived: FPW = DATA_W/FIELD_W fields per word; NF = NUM_WORDS*FPW total fields.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  reset, asynchronous, active-high.
WRITE  input  1  write request, one cycle.
READ  input  1  read request, one cycle.
ADDR  input  ADDR_W  word address.
WRITE_DATA  input  DATA_W  write word.
WRITE_STRB  input  FPW  per-field write enable within the word.
READ_DATA  output  DATA_W  registered read word.
READ_VALID  output  1  pulses 1 cycle after an accepted READ.
ADDR_ERR  output  1  pulses 1 cycle after a READ or WRITE to an unmapped address.
REG_OUT  output  NF*FIELD_W  all field values, field f at bits [f*FIELD_W +: FIELD_W].
HW_SET  input  NF*FIELD_W  hardware set bits for W1C fields; ignored for RW fields.

Behaviour:
- Reset (RST=1, asynchronous): all fields = RESET_VALUE; READ_DATA=0, READ_VALID=0, ADDR_ERR=0.
- Mapping: word k is at ADDR = BASE_ADDR+k, for k in 0..NUM_WORDS-1. Field j of word k is global field f = k*FPW+j, at WRITE_DATA/READ_DATA bits [j*FIELD_W +: FIELD_W]. Field 0 is in the LSBs.
- Mapped means BASE_ADDR <= ADDR < BASE_ADDR+NUM_WORDS. Compare at ADDR_W+1 bits so the addition cannot wrap.
- RW field write: if WRITE, ADDR is mapped to its word, and WRITE_STRB[j]=1, the field takes the slice at the next edge. Fields with strobe 0 hold.
- W1C field per cycle: next = (cur AND NOT clr) OR HW_SET_slice. clr = the write slice when that field is strobed, else 0.
- Same-cycle set and clear on the same bit: set wins, bit stays 1.
- HW_SET has effect every cycle, independent of bus activity.
- Read: if READ and ADDR is mapped, READ_DATA at the next edge = pre-edge field values of that word, and READ_VALID=1 for that cycle.
- READ_DATA holds its value until the next accepted read.
- READ and WRITE to the same address in the same cycle: READ_DATA returns the old value (read-before-write). The write still applies.
- Unmapped access: writes are ignored and no field changes. Reads leave READ_DATA unchanged, and READ_VALID=0.
- ADDR_ERR=1 for exactly the cycle after any unmapped READ or WRITE. It is 0 otherwise, including idle cycles.
- REG_OUT is direct field state: zero latency from the register, one cycle from a write.
- RST asserted mid-sequence: everything returns to reset values immediately. A pending READ_VALID or ADDR_ERR pulse is cancelled.
- Elaboration checks: DATA_W % FIELD_W == 0; BASE_ADDR+NUM_WORDS <= 2**ADDR_W.

Test Plan:
1. Reset, then write ADDR=1, WRITE_DATA=0xB, STRB=2'b11 -> REG_OUT[3:0]=4'b1011 (field0=3, field1=2). Read ADDR=1 -> one cycle later READ_DATA=0xB, READ_VALID=1.
2. Partial strobe: after test 1, write ADDR=1, DATA=0x4, STRB=2'b10 -> field1=1, field0 stays 3; read gives 0x7.
3. W1C: with W1C_MASK bit2=1 (word at ADDR=2, field0), pulse HW_SET[5:4]=2'b11 -> field2=3. Write ADDR=2, DATA=0x1, STRB=2'b01 -> field2=2'b10. Repeat the write with HW_SET[4]=1 in the same cycle -> bit stays 1.
4. Same-cycle READ+WRITE at ADDR=3 (old 0x0, new 0xF) -> READ_DATA=0x0 with READ_VALID=1, then a follow-up read gives 0xF.
5. Unmapped: WRITE at ADDR=0 and ADDR=5 (defaults) -> no REG_OUT change and ADDR_ERR pulses 1 cycle each. READ at ADDR=7 -> READ_VALID=0, READ_DATA unchanged, ADDR_ERR=1.
6. Assert RST asynchronously between edges after writes -> REG_OUT=0 and READ_DATA=0 at once. A read issued in the cycle before reset shows no READ_VALID.
